// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined signed/unsigned multiplier:
// legal parameter ranges, the per-stage sideband record and clog2.
package mult_pkg;

    localparam int W_MIN     = 32'sd4;
    localparam int W_MAX     = 32'sd32;
    localparam int TAG_W_MIN = 32'sd1;
    localparam int TAG_W_MAX = 32'sd16;

    // Travels with every pipeline stage; the tag is sized for the widest
    // legal tag and zero-extended on entry.
    typedef struct packed {
        logic                 valid;
        logic                 neg;
        logic                 z;
        logic [TAG_W_MAX-1:0] tag;
    } side_t;

    // Ceiling log2, used at elaboration time to size the adder tree.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 32'sd0;
        v = n - 32'sd1;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v / 32'sd2;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_add_level.sv
// One registered level of the partial-product adder tree: sums adjacent
// row pairs and forwards the stage sideband, all gated by the global enable.
module mult_add_level
    import mult_pkg::*;
#(
    parameter int ROWS = 2,
    parameter int WID  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [ROWS-1:0][WID-1:0]     rows_in,
    input  side_t                        side_in,
    output logic [ROWS/2-1:0][WID-1:0]   sums_out,
    output side_t                        side_out
);

    // Pairwise sum register plus sideband; holds everything while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sums_out <= '0;
            side_out <= '0;
        end else if (en) begin
            for (int k = 0; k < ROWS / 2; k++) begin
                sums_out[k] <= rows_in[2*k] + rows_in[2*k+1];
            end
            side_out <= side_in;
        end
    end

endmodule

// File: rtl/mult_pipe_su.sv
// Fully pipelined WxW multiplier with per-operand signedness, valid/ready
// flow control and a tag carried alongside each product.
// Pipeline: S0 (magnitudes/sign/zero) -> L adder-tree levels -> N (negate).
module mult_pipe_su
    import mult_pkg::*;
#(
    parameter int W     = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic               a_signed,
    input  logic               b_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     result,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int L     = clog2(W);
    localparam int NROWS = 32'sd1 << L;
    localparam int NTREE = 2 * NROWS - 1;
    localparam int PW    = 2 * W;

    if (W < W_MIN || W > W_MAX || TAG_W < TAG_W_MIN || TAG_W > TAG_W_MAX) begin : g_bad_param
        $error("mult_pipe_su: W or TAG_W outside the supported range");
    end

    // Magnitude of an operand; the most negative signed value maps to 2^(W-1).
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic is_signed);
        logic [W-1:0] m;
        if (is_signed && v[W-1]) begin
            m = ~v + {{(W-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    logic                  adv_s;
    logic [W-1:0]          mag_a_r;
    logic [W-1:0]          mag_b_r;
    side_t                 s0_side_r;
    // All tree rows flattened: level j occupies rows [2*NROWS-2*(NROWS>>j) +: NROWS>>j].
    logic [NTREE-1:0][PW-1:0] tree_s;
    side_t                 side_s [0:L];
    logic [PW-1:0]         sum_s;
    side_t                 fin_side_s;
    logic [PW-1:0]         result_next_s;
    logic                  out_valid_r;
    logic [PW-1:0]         result_r;
    logic [TAG_W-1:0]      out_tag_r;
    logic                  unused_tag_s;

    // One global enable: everything moves unless a product is waiting unclaimed.
    assign adv_s    = ~out_valid_r | out_ready;
    assign in_ready = adv_s & ~rst;

    // S0: operand magnitudes, product sign, zero flag and tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_a_r   <= {W{1'b0}};
            mag_b_r   <= {W{1'b0}};
            s0_side_r <= '0;
        end else if (adv_s) begin
            mag_a_r         <= magnitude(a, a_signed);
            mag_b_r         <= magnitude(b, b_signed);
            s0_side_r.valid <= in_valid;
            s0_side_r.neg   <= (a_signed & a[W-1]) ^ (b_signed & b[W-1]);
            s0_side_r.z     <= (a == {W{1'b0}}) | (b == {W{1'b0}});
            s0_side_r.tag   <= TAG_W_MAX'(in_tag);
        end
    end

    assign side_s[0] = s0_side_r;

    // Partial products from the S0 magnitudes; rows beyond W pad the tree with zero.
    for (genvar i = 0; i < NROWS; i++) begin : g_pp
        if (i < W) begin : g_row
            assign tree_s[i] = ({{W{1'b0}}, mag_a_r} & {PW{mag_b_r[i]}}) << i;
        end else begin : g_pad
            assign tree_s[i] = {PW{1'b0}};
        end
    end

    // Binary adder tree, one registered level per stage.
    for (genvar j = 0; j < L; j++) begin : g_lvl
        localparam int RIN   = NROWS >> j;
        localparam int OFF_I = 2 * NROWS - 2 * RIN;
        localparam int OFF_O = OFF_I + RIN;

        mult_add_level #(
            .ROWS (RIN),
            .WID  (PW)
        ) u_lvl (
            .clk      (clk),
            .rst      (rst),
            .en       (adv_s),
            .rows_in  (tree_s[OFF_I +: RIN]),
            .side_in  (side_s[j]),
            .sums_out (tree_s[OFF_O +: RIN/2]),
            .side_out (side_s[j+1])
        );
    end

    assign sum_s      = tree_s[NTREE-1];
    assign fin_side_s = side_s[L];
    // Only the low TAG_W tag bits leave the block; the rest are constant zero.
    assign unused_tag_s = ^fin_side_s.tag;

    // Sign application: a zero product is forced to 0 so it never carries a sign.
    always_comb begin
        result_next_s = {PW{1'b0}};
        if (fin_side_s.z) begin
            result_next_s = {PW{1'b0}};
        end else if (fin_side_s.neg) begin
            result_next_s = ~sum_s + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            result_next_s = sum_s;
        end
    end

    // Stage N output register; holds result and tag stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= {PW{1'b0}};
            out_tag_r   <= {TAG_W{1'b0}};
        end else if (adv_s) begin
            out_valid_r <= fin_side_s.valid;
            result_r    <= result_next_s;
            out_tag_r   <= fin_side_s.tag[TAG_W-1:0];
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_mult_pipe_su.sv
// Directed bench for mult_pipe_su: W=8 and W=16 instances, sign modes,
// zero handling, latency, backpressure ordering/stability and mid-flight reset.
module tb_mult_pipe_su;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, a_signed, b_signed, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] result;

    logic        w16_in_valid, w16_in_ready, w16_a_signed, w16_b_signed, w16_out_valid, w16_out_ready;
    logic [15:0] w16_a, w16_b;
    logic [3:0]  w16_in_tag, w16_out_tag;
    logic [31:0] w16_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_pipe_su #(.W(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag)
    );

    mult_pipe_su #(.W(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(w16_in_valid), .in_ready(w16_in_ready),
        .a(w16_a), .b(w16_b), .a_signed(w16_a_signed), .b_signed(w16_b_signed), .in_tag(w16_in_tag),
        .out_valid(w16_out_valid), .out_ready(w16_out_ready), .result(w16_result), .out_tag(w16_out_tag)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product for the W=8 instance from plain integer arithmetic.
    function automatic logic [15:0] model8(input logic [7:0] va, input logic [7:0] vb,
                                           input logic sa, input logic sb);
        longint x;
        longint y;
        longint p;
        x = sa ? longint'(signed'(va)) : longint'(va);
        y = sb ? longint'(signed'(vb)) : longint'(vb);
        p = x * y;
        return p[15:0];
    endfunction

    task automatic send8(input string nm, input logic [7:0] va, input logic [7:0] vb,
                         input logic sa, input logic sb, input logic [3:0] tg, input logic [15:0] exp);
        int cyc;
        @(posedge clk); #1;
        a = va; b = vb; a_signed = sa; b_signed = sb; in_tag = tg;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check_eq({nm, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!out_valid && cyc < 20) begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        check_eq({nm, "_lat"}, cyc, 5);
        check_eq({nm, "_res"}, result, exp);
        check_eq({nm, "_tag"}, out_tag, tg);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq({nm, "_drain"}, out_valid, 0);
    endtask

    task automatic send16(input string nm, input logic [15:0] va, input logic [15:0] vb,
                          input logic sa, input logic sb, input logic [3:0] tg, input logic [31:0] exp);
        int cyc;
        @(posedge clk); #1;
        w16_a = va; w16_b = vb; w16_a_signed = sa; w16_b_signed = sb; w16_in_tag = tg;
        w16_in_valid = 1'b1; w16_out_ready = 1'b1;
        @(posedge clk); #1;
        w16_in_valid = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!w16_out_valid && cyc < 20) begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        check_eq({nm, "_lat"}, cyc, 6);
        check_eq({nm, "_res"}, w16_result, exp);
        check_eq({nm, "_tag"}, w16_out_tag, tg);
        @(posedge clk); #1;
    endtask

    logic [7:0]  bp_a [16];
    logic [7:0]  bp_b [16];
    logic [15:0] bp_exp [16];

    initial begin
        int sent, got, seen;
        logic acc, dlv, prev_stall;
        logic [15:0] prev_res;
        logic [3:0]  prev_tag;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 8'd0; b = 8'd0; a_signed = 1'b0; b_signed = 1'b0; in_tag = 4'd0;
        w16_in_valid = 1'b0; w16_out_ready = 1'b1;
        w16_a = 16'd0; w16_b = 16'd0; w16_a_signed = 1'b0; w16_b_signed = 1'b0; w16_in_tag = 4'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_out_tag", out_tag, 0);
        check_eq("rst_w16_out_valid", w16_out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", in_ready, 1);

        // Sign modes and range corners for W=8
        send8("uu_max",   8'd255, 8'd255, 1'b0, 1'b0, 4'd3,  16'hFE01);
        send8("us_neg",   8'd200, 8'hFD,  1'b0, 1'b1, 4'd7,  16'hFDA8);
        send8("ss_minmin",8'h80,  8'h80,  1'b1, 1'b1, 4'd9,  16'h4000);
        send8("ss_m1",    8'hFF,  8'h7F,  1'b1, 1'b1, 4'd1,  16'hFF81);
        send8("us_lo",    8'd255, 8'h80,  1'b0, 1'b1, 4'd2,  16'h8080);
        send8("us_hi",    8'd255, 8'h7F,  1'b0, 1'b1, 4'd4,  16'h7E81);
        send8("zero_a",   8'h00,  8'h80,  1'b1, 1'b1, 4'd5,  16'h0000);
        send8("zero_b",   8'h7F,  8'h00,  1'b1, 1'b0, 4'd6,  16'h0000);

        // Backpressure stream, tags 0..15, random out_ready
        for (int i = 0; i < 16; i++) begin
            bp_a[i]   = 8'($urandom_range(0, 255));
            bp_b[i]   = 8'($urandom_range(0, 255));
            bp_exp[i] = model8(bp_a[i], bp_b[i], i[0], i[1]);
        end
        sent = 0; got = 0; prev_stall = 1'b0; prev_res = 16'd0; prev_tag = 4'd0;
        @(posedge clk); #1;
        a = bp_a[0]; b = bp_b[0]; a_signed = 1'b0; b_signed = 1'b0; in_tag = 4'd0;
        in_valid = 1'b1; out_ready = 1'($urandom_range(0, 1));
        for (int c = 0; c < 400 && got < 16; c++) begin
            @(negedge clk);
            acc = in_valid & in_ready;
            dlv = out_valid & out_ready;
            if (prev_stall) begin
                check_eq("bp_hold_res", result, prev_res);
                check_eq("bp_hold_tag", out_tag, prev_tag);
            end
            if (dlv) begin
                check_eq("bp_tag", out_tag, got[3:0]);
                check_eq("bp_res", result, bp_exp[got]);
                got++;
            end
            prev_stall = out_valid & ~out_ready;
            prev_res = result;
            prev_tag = out_tag;
            @(posedge clk); #1;
            if (acc) sent++;
            if (sent < 16) begin
                a = bp_a[sent]; b = bp_b[sent];
                a_signed = sent[0]; b_signed = sent[1]; in_tag = sent[3:0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        check_eq("bp_count", got, 16);
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check_eq("bp_no_extra", seen, 0);

        // Reset with three transactions in flight
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            a = 8'(k + 1); b = 8'd3; a_signed = 1'b0; b_signed = 1'b0; in_tag = 4'(k);
            in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check_eq("rst_flush", seen, 0);
        send8("rst_new", 8'd12, 8'd10, 1'b0, 1'b0, 4'd11, 16'h0078);

        // W=16 instance
        send16("w16_uu_max",    16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 4'd12, 32'hFFFE0001);
        send16("w16_ss_minmin", 16'h8000, 16'h8000, 1'b1, 1'b1, 4'd13, 32'h40000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
